// File: rtl/cube_top_color_tracker_if.sv
// Bundle between the move/jump controller (master) and the top-colour
// tracker (slave). The tracker drives the colour vector and status back.
interface cube_top_color_tracker_if #(
    parameter int N_cube = 28,
    parameter int IDX_W  = 5
);
    logic [2:0]        qbert_jump;
    logic              done_move;
    logic [IDX_W-1:0]  land_idx;
    logic              clear_level;
    logic [N_cube-1:0] nios_top_color;
    logic [IDX_W-1:0]  color_cnt;
    logic              level_done;
    logic              fall_pulse;
    logic              busy;

    modport master (
        output qbert_jump, done_move, land_idx, clear_level,
        input  nios_top_color, color_cnt, level_done, fall_pulse, busy
    );

    modport slave (
        input  qbert_jump, done_move, land_idx, clear_level,
        output nios_top_color, color_cnt, level_done, fall_pulse, busy
    );
endinterface

// File: rtl/cube_top_color_tracker.sv
// Owns the per-cube "top face coloured" vector fed to every cube_generator.
// Follows the jump handshake (qbert_jump starts, done_move ends), latches
// the landing index, then colours that cube or flags a fall off the pyramid.
// Optional macro CUBE_TOGGLE_EN: a landing inverts the cube bit instead of
// setting it, so stepping on a coloured cube uncolours it.
module cube_top_color_tracker #(
    parameter int N_cube = 28,
    parameter int IDX_W  = 5
) (
    input logic clk,
    input logic reset,
    cube_top_color_tracker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JUMP = 2'd1,
        LAND = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_cube-1:0] color_q, color_d;
    logic              fall_q, fall_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              done_q;

    // Next-state logic: jump handshake, landing update, clear priority
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        color_d = color_q;
        fall_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.qbert_jump != 3'b000) begin
                    state_d = JUMP;
                end
            end
            JUMP: begin
                if (bus.done_move) begin
                    idx_d   = bus.land_idx;
                    state_d = LAND;
                end
            end
            LAND: begin
                state_d = IDLE;
                if (idx_q < IDX_W'(N_cube)) begin
                    for (int i = 0; i < N_cube; i++) begin
                        if (idx_q == IDX_W'(i)) begin
`ifdef CUBE_TOGGLE_EN
                            color_d[i] = ~color_q[i];
`else
                            color_d[i] = 1'b1;
`endif
                        end
                    end
                end else begin
                    fall_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A clear wins over a landing in the same cycle; the fall flag survives
        if (bus.clear_level) begin
            color_d = '0;
        end
    end

    // Popcount of the current vector, registered one cycle behind it
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < N_cube; i++) begin
            cnt_d = cnt_d + IDX_W'(color_q[i]);
        end
    end

    // State, landing index, colour vector and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            color_q <= '0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            color_q <= color_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
            done_q  <= &color_q;
        end
    end

    assign bus.nios_top_color = color_q;
    assign bus.color_cnt      = cnt_q;
    assign bus.level_done     = done_q;
    assign bus.fall_pulse     = fall_q;
    assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_cube_top_color_tracker.sv
// Directed bench for cube_top_color_tracker: reset, single landing,
// repeat landing, fall off pyramid, full level and clear, ignored done_move
// and clear colliding with a landing.
module tb_cube_top_color_tracker;

    localparam int N_cube = 28;
    localparam int IDX_W  = 5;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [N_cube-1:0] expVec;

    cube_top_color_tracker_if #(.N_cube(N_cube), .IDX_W(IDX_W)) bus ();

    cube_top_color_tracker #(.N_cube(N_cube), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison, counted and reported on mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, returning on the following falling edge
    task automatic step();
        @(negedge clk);
    endtask

    // Full jump: start, done_move with index, then through the LAND write edge
    task automatic applyStimulus(input logic [IDX_W-1:0] idx);
        bus.qbert_jump = 3'b001;
        step();
        bus.qbert_jump = 3'b000;
        bus.done_move  = 1'b1;
        bus.land_idx   = idx;
        step();
        bus.done_move  = 1'b0;
        step();
    endtask

    // Directed sequence
    initial begin
        checks = 0;
        errors = 0;
        bus.qbert_jump  = 3'b000;
        bus.done_move   = 1'b0;
        bus.land_idx    = '0;
        bus.clear_level = 1'b0;
        reset = 1'b1;
        step();
        step();
        checkOutput("reset_vec", 32'(bus.nios_top_color), 32'h0);
        checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        reset = 1'b0;
        step();

        // Single landing on cube 5 with latency checks
        bus.qbert_jump = 3'b001;
        step();
        checkOutput("jump_busy", 32'(bus.busy), 32'h1);
        bus.qbert_jump = 3'b000;
        bus.done_move  = 1'b1;
        bus.land_idx   = 5'd5;
        step();
        bus.done_move = 1'b0;
        checkOutput("land_busy", 32'(bus.busy), 32'h1);
        checkOutput("vec_before_write", 32'(bus.nios_top_color), 32'h0);
        step();
        checkOutput("vec_bit5", 32'(bus.nios_top_color), 32'h20);
        checkOutput("cnt_lags", 32'(bus.color_cnt), 32'h0);
        checkOutput("idle_busy", 32'(bus.busy), 32'h0);
        step();
        checkOutput("cnt_one", 32'(bus.color_cnt), 32'h1);

        // Second landing on cube 5
        applyStimulus(5'd5);
        step();
`ifdef CUBE_TOGGLE_EN
        checkOutput("repeat_vec", 32'(bus.nios_top_color), 32'h0);
        checkOutput("repeat_cnt", 32'(bus.color_cnt), 32'h0);
        expVec = '0;
`else
        checkOutput("repeat_vec", 32'(bus.nios_top_color), 32'h20);
        checkOutput("repeat_cnt", 32'(bus.color_cnt), 32'h1);
        expVec = 28'h20;
`endif

        // Fall off the pyramid
        applyStimulus(5'd31);
        checkOutput("fall_pulse", 32'(bus.fall_pulse), 32'h1);
        checkOutput("fall_vec", 32'(bus.nios_top_color), 32'(expVec));
        checkOutput("fall_busy", 32'(bus.busy), 32'h0);
        step();
        checkOutput("fall_one_cycle", 32'(bus.fall_pulse), 32'h0);

        // Colour cube 9, then reset asynchronously in the middle of a jump
        applyStimulus(5'd9);
        checkOutput("vec_bit9", 32'(bus.nios_top_color), 32'(expVec | 28'h200));
        bus.qbert_jump = 3'b010;
        step();
        checkOutput("midjump_busy", 32'(bus.busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_busy", 32'(bus.busy), 32'h0);
        checkOutput("async_vec", 32'(bus.nios_top_color), 32'h0);
        checkOutput("async_cnt", 32'(bus.color_cnt), 32'h0);
        bus.qbert_jump = 3'b000;
        step();
        reset = 1'b0;
        step();

        // Colour every cube in turn
        for (int i = 0; i < N_cube; i++) begin
            applyStimulus(IDX_W'(i));
        end
        checkOutput("full_vec", 32'(bus.nios_top_color), 32'h0FFF_FFFF);
        step();
        checkOutput("full_cnt", 32'(bus.color_cnt), 32'd28);
        checkOutput("full_done", 32'(bus.level_done), 32'h1);
        bus.clear_level = 1'b1;
        step();
        bus.clear_level = 1'b0;
        checkOutput("clear_vec", 32'(bus.nios_top_color), 32'h0);
        checkOutput("clear_done_lags", 32'(bus.level_done), 32'h1);
        step();
        checkOutput("clear_done", 32'(bus.level_done), 32'h0);
        checkOutput("clear_cnt", 32'(bus.color_cnt), 32'h0);

        // done_move while idle is ignored
        bus.done_move = 1'b1;
        bus.land_idx  = 5'd3;
        step();
        bus.done_move = 1'b0;
        checkOutput("idle_done_busy", 32'(bus.busy), 32'h0);
        step();
        step();
        checkOutput("idle_done_vec", 32'(bus.nios_top_color), 32'h0);

        // Clear in the same cycle as a landing on cube 7
        bus.qbert_jump = 3'b100;
        step();
        bus.qbert_jump = 3'b000;
        bus.done_move  = 1'b1;
        bus.land_idx   = 5'd7;
        step();
        bus.done_move   = 1'b0;
        bus.clear_level = 1'b1;
        step();
        bus.clear_level = 1'b0;
        checkOutput("clear_wins_vec", 32'(bus.nios_top_color), 32'h0);
        checkOutput("clear_wins_busy", 32'(bus.busy), 32'h0);
        step();
        checkOutput("clear_wins_cnt", 32'(bus.color_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
